// File: rtl/kore_ifetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, IR handshake toward the op FSM,
// and the branch redirect/error sideband. master = fetch stage, slave = its environment.
interface kore_ifetch_if #(
    parameter int ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              ir_valid;
    logic              ir_ready;
    logic [31:0]       IR_code;
    logic [ADDR_W-1:0] ir_pc;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              fetch_err;

    modport master (
        output imem_req, imem_addr, ir_valid, IR_code, ir_pc, fetch_err,
        input  imem_gnt, imem_rvalid, imem_rdata, ir_ready, br_taken, br_target
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, IR_code, ir_pc, fetch_err,
        output imem_gnt, imem_rvalid, imem_rdata, ir_ready, br_taken, br_target
    );
endinterface

// File: rtl/kore_ifetch.sv
// Instruction fetch: PC owner, single-outstanding imem reads, IR valid/ready toward op FSM.
// Define KORE_IFETCH_ALIGN_CHK_EN to trap misaligned branch targets into a sticky ERR state.
module kore_ifetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    kore_ifetch_if.master bus
);
`ifdef KORE_IFETCH_ALIGN_CHK_EN
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD} state_t;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc, pc_req, ir_pc_q;
    logic [31:0]       ir_code_q;
    logic              kill, req_q, vld_q;
    logic [ADDR_W-1:0] br_pc;
    logic              br_bad;
    logic              wait_drop;

    assign br_pc     = {bus.br_target[ADDR_W-1:2], 2'b00};
    // A same-cycle redirect makes the returning word just as stale as an earlier one.
    assign wait_drop = kill | bus.br_taken;

`ifdef KORE_IFETCH_ALIGN_CHK_EN
    logic fetch_err_q;
    logic in_err;
    assign br_bad        = bus.br_taken & (|bus.br_target[1:0]);
    assign in_err        = (state == ERR);
    assign bus.fetch_err = fetch_err_q;
`else
    logic in_err;
    logic unused_br_lo;
    assign br_bad        = 1'b0;
    assign in_err        = 1'b0;
    assign unused_br_lo  = ^bus.br_target[1:0];
    assign bus.fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            pc_req    <= RESET_PC;
            kill      <= 1'b0;
            req_q     <= 1'b0;
            vld_q     <= 1'b0;
            ir_code_q <= 32'h0;
            ir_pc_q   <= RESET_PC;
`ifdef KORE_IFETCH_ALIGN_CHK_EN
            fetch_err_q <= 1'b0;
`endif
        end else if (!in_err) begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req_q <= 1'b1;
                end
                REQ: begin
                    if (bus.imem_gnt) begin
                        state  <= WAIT;
                        req_q  <= 1'b0;
                        pc_req <= pc;
                        if (bus.br_taken) kill <= 1'b1;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        if (wait_drop) begin
                            kill  <= 1'b0;
                            state <= REQ;
                            req_q <= 1'b1;
                        end else begin
                            ir_code_q <= bus.imem_rdata;
                            ir_pc_q   <= pc_req;
                            pc        <= pc_req + ADDR_W'(4);
                            state     <= HOLD;
                            vld_q     <= 1'b1;
                        end
                    end else if (bus.br_taken) begin
                        kill <= 1'b1;
                    end
                end
                HOLD: begin
                    // Redirect discards an unconsumed word; a same-cycle ready still consumes it.
                    if (bus.ir_ready || bus.br_taken) begin
                        state <= REQ;
                        vld_q <= 1'b0;
                        req_q <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                    vld_q <= 1'b0;
                end
            endcase

            if (bus.br_taken) pc <= br_pc;

`ifdef KORE_IFETCH_ALIGN_CHK_EN
            if (br_bad) begin
                state       <= ERR;
                req_q       <= 1'b0;
                vld_q       <= 1'b0;
                fetch_err_q <= 1'b1;
            end
`endif
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc;
    assign bus.ir_valid  = vld_q;
    assign bus.IR_code   = ir_code_q;
    assign bus.ir_pc     = ir_pc_q;

    logic unused_br_bad;
    assign unused_br_bad = br_bad;
endmodule

// File: tb/tb_kore_ifetch.sv
// Directed bench for kore_ifetch: drives imem/IR/branch by hand, samples 1ns after each edge.
module tb_kore_ifetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    kore_ifetch_if #(.ADDR_W(32)) bus ();

    kore_ifetch #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && bus.ir_valid && bus.ir_ready) hs_cnt <= hs_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.ir_ready    = 1'b0;
        bus.br_taken    = 1'b0;
        bus.br_target   = 32'h0;
        tick(); tick();

        chk("rst_req",   {31'h0, bus.imem_req},  32'h0);
        chk("rst_addr",  bus.imem_addr,          32'h0);
        chk("rst_vld",   {31'h0, bus.ir_valid},  32'h0);
        chk("rst_ir",    bus.IR_code,            32'h0);
        chk("rst_irpc",  bus.ir_pc,              32'h0);
        chk("rst_err",   {31'h0, bus.fetch_err}, 32'h0);

        // reset release: IDLE one cycle, then REQ
        rst_n = 1'b1;
        tick();
        chk("first_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("first_addr", bus.imem_addr,         32'h0);

        // basic fetch
        bus.imem_gnt = 1'b1;
        tick();
        chk("wait_noreq", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_7063;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("f1_vld",  {31'h0, bus.ir_valid}, 32'h1);
        chk("f1_ir",   bus.IR_code,           32'h0000_7063);
        chk("f1_irpc", bus.ir_pc,             32'h0);

        // stall in HOLD for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_vld",  {31'h0, bus.ir_valid}, 32'h1);
            chk("hold_ir",   bus.IR_code,           32'h0000_7063);
            chk("hold_irpc", bus.ir_pc,             32'h0);
            chk("hold_req",  {31'h0, bus.imem_req}, 32'h0);
        end
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        chk("hs_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("hs_addr", bus.imem_addr,         32'h4);
        chk("hs_vld",  {31'h0, bus.ir_valid}, 32'h0);

        // redirect during WAIT, stale word dropped
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0; bus.br_taken = 1'b1; bus.br_target = 32'h100;
        tick();
        bus.br_taken = 1'b0;
        chk("kill_wait_req", {31'h0, bus.imem_req}, 32'h0);
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("kill_vld",  {31'h0, bus.ir_valid}, 32'h0);
        chk("kill_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("kill_addr", bus.imem_addr,         32'h100);
        chk("kill_ir",   bus.IR_code,           32'h0000_7063);

        // redirect with same-cycle handshake in HOLD
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0010_0093;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("f2_ir",   bus.IR_code, 32'h0010_0093);
        chk("f2_irpc", bus.ir_pc,   32'h100);
        bus.ir_ready = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h200;
        tick();
        bus.ir_ready = 1'b0; bus.br_taken = 1'b0;
        chk("brhs_vld",  {31'h0, bus.ir_valid}, 32'h0);
        chk("brhs_req",  {31'h0, bus.imem_req}, 32'h1);
        chk("brhs_addr", bus.imem_addr,         32'h200);
        chk("brhs_cnt",  hs_cnt,                32'd2);

        // redirect in REQ without grant, then PC wrap
        bus.br_taken = 1'b1; bus.br_target = 32'hFFFF_FFFC;
        tick();
        bus.br_taken = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000_0013;
        tick();
        bus.imem_rvalid = 1'b0;
        chk("wrap_irpc", bus.ir_pc, 32'hFFFF_FFFC);
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;
        chk("wrap_next", bus.imem_addr, 32'h0);
        chk("wrap_req",  {31'h0, bus.imem_req}, 32'h1);

        // misaligned redirect target
        bus.br_taken = 1'b1; bus.br_target = 32'h102;
        tick();
        bus.br_taken = 1'b0;
`ifdef KORE_IFETCH_ALIGN_CHK_EN
        chk("mis_err", {31'h0, bus.fetch_err}, 32'h1);
        bus.imem_gnt = 1'b1; bus.ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_noreq", {31'h0, bus.imem_req}, 32'h0);
            chk("err_novld", {31'h0, bus.ir_valid}, 32'h0);
        end
        bus.imem_gnt = 1'b0; bus.ir_ready = 1'b0;
`else
        chk("mis_addr", bus.imem_addr,         32'h100);
        chk("mis_err",  {31'h0, bus.fetch_err}, 32'h0);
        chk("mis_req",  {31'h0, bus.imem_req},  32'h1);
        bus.imem_gnt = 1'b1;
        tick();
        bus.imem_gnt = 1'b0;
`endif

        // asynchronous reset mid-transaction
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req",  {31'h0, bus.imem_req},  32'h0);
        chk("arst_addr", bus.imem_addr,          32'h0);
        chk("arst_err",  {31'h0, bus.fetch_err}, 32'h0);
        chk("arst_irpc", bus.ir_pc,              32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
